// File: rtl/reg_file.sv
// 16x8 register file: two combinational read ports, one synchronous write port, R[OUT_ADDR] mirrored on cpu_out.
// Write takes effect on the rising edge (no read bypass); reads are zero-latency; no backpressure, every write strobe is accepted.
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OUT_ADDR   = 15
) (
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] RA2,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clk,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] cpu_out,
  input  logic                  reset
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Only a definite 1 writes; an unknown strobe is treated as idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable == 1'b1) begin
      regs[WA] <= data_in;
    end
  end

  assign data_out1 = regs[RA1];
  assign data_out2 = regs[RA2];
  assign cpu_out   = regs[OUT_ADDR];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

  logic       clk;
  logic       reset;
  logic [3:0] RA1, RA2, WA;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out1, data_out2, cpu_out;

  int vectors;
  int miscompares;

  logic [7:0] mdl [16];

  reg_file dut (
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .data_in      (data_in),
    .clk          (clk),
    .write_enable (write_enable),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .cpu_out      (cpu_out),
    .reset        (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
  endtask

  // Advance one rising edge, applying the architectural write rule to the model.
  task automatic clock_edge();
    @(posedge clk);
    if (reset === 1'b1 && write_enable === 1'b1) mdl[WA] = data_in;
    #1;
  endtask

  task automatic drive(input logic [3:0] wa, input logic [7:0] d, input logic we,
                       input logic [3:0] ra1, input logic [3:0] ra2);
    @(negedge clk);
    WA = wa; data_in = d; write_enable = we; RA1 = ra1; RA2 = ra2;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    WA = 4'd7; data_in = 8'hC3; write_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i); RA2 = 4'(15 - i);
      #1;
      vectors++;
      if (data_out1 !== 8'h00 || data_out2 !== 8'h00 || cpu_out !== 8'h00) begin
        miscompares++;
        $display("FAIL reset ra=%0d: got out1=%h out2=%h cpu=%h, want 00 00 00", i, data_out1, data_out2, cpu_out);
      end
    end
    mdl_clear();
    @(negedge clk);
    write_enable = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic_write();
    drive(4'd10, 8'h03, 1'b1, 4'd10, 4'd1);
    clock_edge();
    vectors++;
    if (data_out1 !== 8'h03 || data_out2 !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_write: got out1=%h out2=%h, want 03 00", data_out1, data_out2);
    end
  endtask

  task automatic test_write_disabled();
    drive(4'd12, 8'h24, 1'b0, 4'd12, 4'd10);
    clock_edge();
    vectors++;
    if (data_out1 !== 8'h00 || data_out2 !== 8'h03) begin
      miscompares++;
      $display("FAIL write_disabled: got r12=%h r10=%h, want 00 03", data_out1, data_out2);
    end
  endtask

  task automatic test_output_reg();
    drive(4'd15, 8'hF1, 1'b1, 4'd10, 4'd1);
    vectors++;
    if (cpu_out !== 8'h00) begin
      miscompares++;
      $display("FAIL cpu_out_before_edge: got %h, want 00", cpu_out);
    end
    clock_edge();
    vectors++;
    if (cpu_out !== 8'hF1 || data_out1 !== 8'h03 || data_out2 !== 8'h00) begin
      miscompares++;
      $display("FAIL output_reg: got cpu=%h out1=%h out2=%h, want F1 03 00", cpu_out, data_out1, data_out2);
    end
  endtask

  task automatic test_read_during_write();
    drive(4'd5, 8'hAA, 1'b1, 4'd5, 4'd5);
    vectors++;
    if (data_out1 !== 8'h00 || data_out2 !== 8'h00) begin
      miscompares++;
      $display("FAIL rdw_before_edge: got out1=%h out2=%h, want 00 00", data_out1, data_out2);
    end
    clock_edge();
    vectors++;
    if (data_out1 !== 8'hAA || data_out2 !== 8'hAA) begin
      miscompares++;
      $display("FAIL rdw_after_edge: got out1=%h out2=%h, want AA AA", data_out1, data_out2);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'd3, 8'h55, 1'b1, 4'd3, 4'd15);
    clock_edge();
    vectors++;
    if (data_out1 !== 8'h55 || cpu_out !== 8'hF1) begin
      miscompares++;
      $display("FAIL reset_mid_preload: got r3=%h cpu=%h, want 55 F1", data_out1, cpu_out);
    end
    @(negedge clk);
    write_enable = 1'b0;
    #1 reset = 1'b0;
    #1;
    mdl_clear();
    vectors++;
    if (data_out1 !== 8'h00 || data_out2 !== 8'h00 || cpu_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got r3=%h r15=%h cpu=%h, want 00 00 00", data_out1, data_out2, cpu_out);
    end
    #1 reset = 1'b1;
    drive(4'd3, 8'h77, 1'b1, 4'd3, 4'd5);
    clock_edge();
    vectors++;
    if (data_out1 !== 8'h77 || data_out2 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_rewrite: got r3=%h r5=%h, want 77 00", data_out1, data_out2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(15)), 8'($urandom_range(255)), 1'($urandom_range(1)),
            4'($urandom_range(15)), 4'($urandom_range(15)));
      // Outputs still reflect pre-edge contents even when an address matches WA.
      vectors++;
      if (data_out1 !== mdl[RA1] || data_out2 !== mdl[RA2] || cpu_out !== mdl[15]) begin
        miscompares++;
        $display("FAIL random_pre n=%0d ra1=%0d ra2=%0d: got %h %h %h, want %h %h %h",
                 n, RA1, RA2, data_out1, data_out2, cpu_out, mdl[RA1], mdl[RA2], mdl[15]);
      end
      clock_edge();
      vectors++;
      if (data_out1 !== mdl[RA1] || data_out2 !== mdl[RA2] || cpu_out !== mdl[15]) begin
        miscompares++;
        $display("FAIL random_post n=%0d ra1=%0d ra2=%0d: got %h %h %h, want %h %h %h",
                 n, RA1, RA2, data_out1, data_out2, cpu_out, mdl[RA1], mdl[RA2], mdl[15]);
      end
    end
  endtask

  task automatic test_full_sweep();
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 8'(8'h10 * i + 8'h0F - i), 1'b1, 4'(i), 4'(15 - i));
      clock_edge();
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      RA1 = 4'(i); RA2 = 4'(15 - i); write_enable = 1'b0;
      #1;
      vectors++;
      if (data_out1 !== 8'(8'h10 * i + 8'h0F - i) || data_out2 !== mdl[15 - i]) begin
        miscompares++;
        $display("FAIL sweep r%0d: got %h %h, want %h %h", i, data_out1, data_out2,
                 8'(8'h10 * i + 8'h0F - i), mdl[15 - i]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    RA1 = '0; RA2 = '0; WA = '0; data_in = '0; write_enable = 1'b0;
    mdl_clear();
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_output_reg();
    test_read_during_write();
    test_reset_mid();
    test_random();
    test_full_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
